// File: rtl/wake_controller.sv
// UART low-power wake controller: drains the link, sleeps with the datapath clock gated,
// and wakes on a glitch-qualified RX low level or a host transmit request.
module wake_controller #(
  parameter int unsigned WAKE_DELAY    = 16,
  parameter int unsigned GLITCH_CYCLES = 8
) (
  input  logic       i_Clock,
  input  logic       i_reset,
  input  logic       enter_sleep,
  input  logic       TX_Active,
  input  logic       RX_Active,
  input  logic       i_RX_Serial,
  input  logic       i_TX_Request,
  output logic       o_Clk_Enable,
  output logic       o_Sleeping,
  output logic       o_Ready,
  output logic       o_Wake_Pulse,
  output logic [1:0] o_Wake_Source
);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SLEEP  = 3'd2,
    ST_FILTER = 3'd3,
    ST_WAKEUP = 3'd4
  } state_t;

  localparam logic [15:0] DELAY_LAST = 16'(WAKE_DELAY - 1);
  localparam logic [7:0]  GLITCH_MAX = 8'(GLITCH_CYCLES);

  state_t      state_r;
  state_t      state_s;
  logic        rx_meta_r;
  logic        rx_sync_r;
  logic        rearm_r;
  logic [7:0]  glitch_cnt_r;
  logic [7:0]  glitch_cnt_s;
  logic [7:0]  glitch_inc_s;
  logic [15:0] delay_cnt_r;
  logic [15:0] delay_cnt_s;
  logic [1:0]  wake_src_r;
  logic [1:0]  wake_src_s;
  logic        wake_pulse_r;
  logic        wake_done_s;

  // Two-flop synchroniser for the asynchronous RX line (idle high).
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_RX_Serial;
      rx_sync_r <= rx_meta_r;
    end
  end

  // State, counters, wake source, rearm flag and wake strobe registers.
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= ST_ACTIVE;
      glitch_cnt_r <= 8'd0;
      delay_cnt_r  <= 16'd0;
      wake_src_r   <= 2'b00;
      rearm_r      <= 1'b1;
      wake_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      glitch_cnt_r <= glitch_cnt_s;
      delay_cnt_r  <= delay_cnt_s;
      wake_src_r   <= wake_src_s;
      wake_pulse_r <= wake_done_s;
      // Completion of a wake disarms sleep until the power manager deasserts its request.
      if (wake_done_s) begin
        rearm_r <= 1'b0;
      end else if (!enter_sleep) begin
        rearm_r <= 1'b1;
      end else begin
        rearm_r <= rearm_r;
      end
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_s      = state_r;
    glitch_cnt_s = glitch_cnt_r;
    delay_cnt_s  = delay_cnt_r;
    wake_src_s   = wake_src_r;
    wake_done_s  = 1'b0;
    glitch_inc_s = (glitch_cnt_r == 8'hFF) ? glitch_cnt_r : glitch_cnt_r + 8'd1;
    case (state_r)
      ST_ACTIVE: begin
        if (enter_sleep && rearm_r) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (!enter_sleep || i_TX_Request) begin
          state_s = ST_ACTIVE;
        end else if (!TX_Active && !RX_Active && rx_sync_r) begin
          state_s = ST_SLEEP;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_SLEEP: begin
        if (i_TX_Request) begin
          state_s     = ST_WAKEUP;
          wake_src_s  = rx_sync_r ? 2'b10 : 2'b11;
          delay_cnt_s = 16'd0;
        end else if (!rx_sync_r) begin
          if (GLITCH_MAX <= 8'd1) begin
            state_s     = ST_WAKEUP;
            wake_src_s  = 2'b01;
            delay_cnt_s = 16'd0;
          end else begin
            state_s      = ST_FILTER;
            glitch_cnt_s = 8'd1;
          end
        end else begin
          state_s = ST_SLEEP;
        end
      end
      ST_FILTER: begin
        if (i_TX_Request) begin
          state_s     = ST_WAKEUP;
          wake_src_s  = 2'b11;
          delay_cnt_s = 16'd0;
        end else if (rx_sync_r) begin
          state_s = ST_SLEEP;
        end else begin
          glitch_cnt_s = glitch_inc_s;
          if (glitch_inc_s >= GLITCH_MAX) begin
            state_s     = ST_WAKEUP;
            wake_src_s  = 2'b01;
            delay_cnt_s = 16'd0;
          end else begin
            state_s = ST_FILTER;
          end
        end
      end
      ST_WAKEUP: begin
        if (delay_cnt_r >= DELAY_LAST) begin
          state_s     = ST_ACTIVE;
          wake_done_s = 1'b1;
        end else begin
          delay_cnt_s = delay_cnt_r + 16'd1;
          state_s     = ST_WAKEUP;
        end
      end
      default: begin
        state_s = ST_ACTIVE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    o_Clk_Enable = 1'b1;
    o_Sleeping   = 1'b0;
    o_Ready      = 1'b0;
    case (state_r)
      ST_ACTIVE: begin
        o_Ready = 1'b1;
      end
      ST_SLEEP, ST_FILTER: begin
        o_Clk_Enable = 1'b0;
        o_Sleeping   = 1'b1;
      end
      default: begin
        o_Clk_Enable = 1'b1;
      end
    endcase
  end

  assign o_Wake_Pulse  = wake_pulse_r;
  assign o_Wake_Source = wake_src_r;

endmodule

// File: doc/wake_controller.md
WAKE_CONTROLLER -- requirements
Module: wake_controller

Interface
REQ-001 Parameter WAKE_DELAY, default 16: cycles of power-up settle time held in WAKEUP before returning to ACTIVE, legal range 1..65535.
REQ-002 Parameter GLITCH_CYCLES, default 8: consecutive synchronised-low RX cycles required to qualify a wake, legal range 1..255.
REQ-003 i_Clock  input  1  single clock for all logic.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 enter_sleep  input  1  sleep request from the idle-timeout power manager, level.
REQ-006 TX_Active  input  1  transmitter busy.
REQ-007 RX_Active  input  1  receiver busy.
REQ-008 i_RX_Serial  input  1  raw asynchronous serial line, idle high.
REQ-009 i_TX_Request  input  1  host request to transmit, level.
REQ-010 o_Clk_Enable  output  1  clock-gate enable for the UART datapath.
REQ-011 o_Sleeping  output  1  high while in SLEEP or FILTER.
REQ-012 o_Ready  output  1  high only in ACTIVE.
REQ-013 o_Wake_Pulse  output  1  single-cycle strobe on completion of a wake.
REQ-014 o_Wake_Source  output  2  cause of the last wake: 01 = RX, 10 = TX request, 11 = both.

Function
REQ-015 i_RX_Serial SHALL pass through a 2-flop synchroniser (reset value 1); all RX decisions SHALL use the second flop (rx_s).
REQ-016 States: ACTIVE, DRAIN, SLEEP, FILTER, WAKEUP; all outputs SHALL be registered or decoded from registered state only.
REQ-017 A rearm flag SHALL be cleared on every entry to ACTIVE from WAKEUP and set whenever enter_sleep=0.
REQ-018 ACTIVE -> DRAIN when enter_sleep=1 and rearm=1; otherwise stay.
REQ-019 DRAIN -> ACTIVE if enter_sleep=0 or i_TX_Request=1 (abort, no wake pulse, source unchanged).
REQ-020 DRAIN -> SLEEP when TX_Active=0, RX_Active=0 and rx_s=1 in the same cycle and no abort condition holds; otherwise stay in DRAIN.
REQ-021 SLEEP: if i_TX_Request=1 and rx_s=0 -> WAKEUP with source 11; else if i_TX_Request=1 -> WAKEUP with source 10; else if rx_s=0 -> FILTER with the glitch counter loaded to 1.
REQ-022 FILTER: i_TX_Request=1 -> WAKEUP with source 11; else if rx_s=1 -> SLEEP (glitch rejected, no pulse, source unchanged); else increment the counter, -> WAKEUP with source 01 when the counter reaches GLITCH_CYCLES.
REQ-023 With GLITCH_CYCLES=1, a single low rx_s sample in SLEEP SHALL go directly to WAKEUP with source 01.
REQ-024 WAKEUP: the delay counter SHALL be loaded with 0 on entry and increment each cycle; -> ACTIVE after exactly WAKE_DELAY cycles in WAKEUP; inputs are ignored in WAKEUP.
REQ-025 o_Wake_Pulse SHALL be 1 for exactly the first cycle in ACTIVE after WAKEUP, and 0 at all other times.
REQ-026 o_Wake_Source SHALL update on entry to WAKEUP and hold until the next WAKEUP entry.
REQ-027 o_Clk_Enable SHALL be 0 in SLEEP and FILTER and 1 in ACTIVE, DRAIN and WAKEUP.
REQ-028 Counters SHALL saturate and never wrap; counter widths SHALL be sized to the parameter ranges.

Reset
REQ-029 While i_reset=0: state ACTIVE, rearm=1, rx sync flops=1, counters=0, o_Clk_Enable=1, o_Ready=1, o_Sleeping=0, o_Wake_Pulse=0, o_Wake_Source=00.
REQ-030 Asserting reset mid-SLEEP, mid-FILTER or mid-WAKEUP SHALL force the reset values immediately (asynchronously); the first post-reset decision SHALL occur on the first rising edge after i_reset=1.

Verification
REQ-031 enter_sleep=1, TX_Active=RX_Active=0, rx line=1 -> DRAIN for 1 cycle, then SLEEP; o_Clk_Enable=0, o_Sleeping=1, o_Ready=0.
REQ-032 In SLEEP, drive RX low for 5 cycles then high (GLITCH_CYCLES=8) -> SLEEP is re-entered, no o_Wake_Pulse, o_Wake_Source unchanged.
REQ-033 In SLEEP, drive RX low for 8 cycles -> WAKEUP, source=01, o_Clk_Enable=1; after 16 cycles -> ACTIVE with a one-cycle o_Wake_Pulse.
REQ-034 In SLEEP, raise i_TX_Request on the same edge that rx_s falls -> WAKEUP with source=11.
REQ-035 After a wake with enter_sleep held at 1 -> stays in ACTIVE; drop enter_sleep for 1 cycle, then raise it -> DRAIN.
REQ-036 Pulse i_reset low during WAKEUP -> outputs take the reset values asynchronously; after release -> ACTIVE, o_Wake_Source=00, no o_Wake_Pulse.
